// File: rtl/life_engine.sv
// life_engine: ROWS x COLS Game-of-Life grid, B3/S23 rule, with
// run/step/halt control, generation-rate divider and stable/extinct flags.
module life_engine #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int TICK_DIV  = 1,
    parameter int GEN_W     = 16,
    parameter bit AUTO_HALT = 1'b1
) (
    input  logic                 clk,
    input  logic                 flopreset,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 run,
    input  logic                 step,
    input  logic                 wrap_en,
    input  logic                 show_seed,
    output logic [ROWS*COLS-1:0] grid_out,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 stable,
    output logic                 extinct,
    output logic                 running
);
    localparam int N  = ROWS * COLS;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [N-1:0]     r_grid;
    logic [GEN_W-1:0] r_gen;
    logic             r_stable;
    logic [TW-1:0]    r_tick;

    logic [N-1:0]     w_next;
    logic             w_same;
    logic             w_dead;
    logic             w_tick_end;
    logic             w_tick_clr;
    logic             w_evolve;

    // Off-grid neighbours are masked to 0 unless the torus is enabled.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int RU  = (r + ROWS - 1) % ROWS;
            localparam int RD  = (r + 1) % ROWS;
            localparam int CL  = (c + COLS - 1) % COLS;
            localparam int CR  = (c + 1) % COLS;
            localparam bit TOP = (r == 0);
            localparam bit BOT = (r == ROWS - 1);
            localparam bit LFT = (c == 0);
            localparam bit RGT = (c == COLS - 1);

            logic       w_up;
            logic       w_dn;
            logic       w_lf;
            logic       w_rt;
            logic [7:0] w_nb;
            logic [3:0] w_n;

            assign w_up = wrap_en | ~TOP;
            assign w_dn = wrap_en | ~BOT;
            assign w_lf = wrap_en | ~LFT;
            assign w_rt = wrap_en | ~RGT;

            assign w_nb[0] = r_grid[RU*COLS+CL] & w_up & w_lf;
            assign w_nb[1] = r_grid[RU*COLS+c]  & w_up;
            assign w_nb[2] = r_grid[RU*COLS+CR] & w_up & w_rt;
            assign w_nb[3] = r_grid[r*COLS+CL]  & w_lf;
            assign w_nb[4] = r_grid[r*COLS+CR]  & w_rt;
            assign w_nb[5] = r_grid[RD*COLS+CL] & w_dn & w_lf;
            assign w_nb[6] = r_grid[RD*COLS+c]  & w_dn;
            assign w_nb[7] = r_grid[RD*COLS+CR] & w_dn & w_rt;

            always_comb begin
                w_n = '0;
                for (int i = 0; i < 8; i++) begin
                    w_n = w_n + {3'b000, w_nb[i]};
                end
            end

            assign w_next[r*COLS+c] = (w_n == 4'd3) |
                                      (r_grid[r*COLS+c] & (w_n == 4'd2));
        end
    end

    assign w_same     = (w_next == r_grid);
    assign w_dead     = (w_next == '0);
    assign w_tick_end = (r_tick == TW'(TICK_DIV - 1));

    always_comb begin
        w_state_nx = r_state;
        w_evolve   = 1'b0;
        w_tick_clr = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nx = S_RUN;
                end else if (step) begin
                    w_evolve = 1'b1;
                end
            end
            S_RUN: begin
                if (!run) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_tick_clr = w_tick_end;
                    if (w_tick_end) begin
                        w_evolve = 1'b1;
                        if (AUTO_HALT && (w_same || w_dead)) begin
                            w_state_nx = S_HALT;
                        end
                    end
                end
            end
            S_HALT: begin
                if (!run) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Load overrides every state and any pending evolution.
    always_ff @(posedge clk or posedge flopreset) begin
        if (flopreset) begin
            r_state  <= S_IDLE;
            r_grid   <= '0;
            r_gen    <= '0;
            r_stable <= 1'b0;
            r_tick   <= '0;
        end else if (load) begin
            r_state  <= S_IDLE;
            r_grid   <= seed;
            r_gen    <= '0;
            r_stable <= 1'b0;
            r_tick   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_tick  <= w_tick_clr ? '0 : r_tick + TW'(1);
            if (w_evolve) begin
                r_grid   <= w_next;
                r_stable <= w_same;
                if (r_gen != '1) begin
                    r_gen <= r_gen + GEN_W'(1);
                end
            end
        end
    end

    assign grid_out  = show_seed ? seed : r_grid;
    assign gen_count = r_gen;
    assign stable    = r_stable;
    assign extinct   = (r_grid == '0);
    assign running   = (r_state == S_RUN);

endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed + random checks of life_engine against a
// cell-by-cell Game-of-Life reference and a run/pause/halt mode model.
module tb_life_engine;
    localparam int M_PAUSE = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;

    logic        clk;
    logic        flopreset;
    logic        load;
    logic [63:0] seed;
    logic        run;
    logic        step;
    logic        wrap_en;
    logic        show_seed;
    logic [63:0] grid_out;
    logic [15:0] gen_count;
    logic        stable;
    logic        extinct;
    logic        running;

    logic [63:0] div_grid;
    logic [2:0]  div_gen;
    logic        div_stable;
    logic        div_extinct;
    logic        div_running;

    int          n_checks;
    int          n_err;

    logic [63:0] m_grid;
    int          m_gen;
    bit          m_stable;
    int          m_mode;

    life_engine #(.ROWS(8), .COLS(8), .TICK_DIV(1), .GEN_W(16), .AUTO_HALT(1'b1)) u_dut (
        .clk(clk), .flopreset(flopreset), .load(load), .seed(seed),
        .run(run), .step(step), .wrap_en(wrap_en), .show_seed(show_seed),
        .grid_out(grid_out), .gen_count(gen_count), .stable(stable),
        .extinct(extinct), .running(running)
    );

    life_engine #(.ROWS(8), .COLS(8), .TICK_DIV(4), .GEN_W(3), .AUTO_HALT(1'b1)) u_div (
        .clk(clk), .flopreset(flopreset), .load(load), .seed(seed),
        .run(run), .step(step), .wrap_en(wrap_en), .show_seed(1'b0),
        .grid_out(div_grid), .gen_count(div_gen), .stable(div_stable),
        .extinct(div_extinct), .running(div_running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] life(input logic [63:0] g, input logic wrap);
        logic [63:0] nx;
        int n;
        int rr;
        int cc;
        nx = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                        end
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            n += int'(g[rr*8+cc]);
                    end
                end
                nx[r*8+c] = (n == 3) || (g[r*8+c] && n == 2);
            end
        end
        return nx;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_grid   = '0;
        m_gen    = 0;
        m_stable = 1'b0;
        m_mode   = M_PAUSE;
    endtask

    task automatic evolve();
        logic [63:0] nx;
        nx       = life(m_grid, wrap_en);
        m_stable = (nx == m_grid);
        m_grid   = nx;
        if (m_gen < 65535) m_gen++;
    endtask

    task automatic model_edge();
        logic [63:0] nx;
        if (load) begin
            m_grid   = seed;
            m_gen    = 0;
            m_stable = 1'b0;
            m_mode   = M_PAUSE;
        end else if (m_mode == M_PAUSE) begin
            if (run) m_mode = M_RUN;
            else if (step) evolve();
        end else if (m_mode == M_RUN) begin
            if (!run) begin
                m_mode = M_PAUSE;
            end else begin
                nx = life(m_grid, wrap_en);
                if (nx == m_grid || nx == 0) m_mode = M_HALT;
                evolve();
            end
        end else begin
            if (!run) m_mode = M_PAUSE;
        end
    endtask

    task automatic check_all();
        check("grid_out", grid_out, show_seed ? seed : m_grid);
        check("gen_count", 64'(gen_count), 64'(m_gen));
        check("stable", 64'(stable), 64'(m_stable));
        check("extinct", 64'(extinct), 64'(m_grid == 0));
        check("running", 64'(running), 64'(m_mode == M_RUN));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_load(input logic [63:0] s);
        seed = s;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1;
        cyc();
        step = 1'b0;
    endtask

    initial begin
        logic [63:0] blk_h;
        logic [63:0] blk_v;
        n_checks  = 0;
        n_err     = 0;
        flopreset = 1'b1;
        load      = 1'b0;
        seed      = '0;
        run       = 1'b0;
        step      = 1'b0;
        wrap_en   = 1'b0;
        show_seed = 1'b0;
        blk_h = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
        blk_v = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
        model_reset();
        #2;
        check_all();
        check("rst_extinct", 64'(extinct), 64'd1);
        #1 flopreset = 1'b0;

        // blinker under single step
        do_load(blk_h);
        do_step();
        check("t1_grid_v", grid_out, blk_v);
        check("t1_gen1", 64'(gen_count), 64'd1);
        do_step();
        check("t1_grid_h", grid_out, blk_h);
        check("t1_stable", 64'(stable), 64'd0);

        // dead edge, then torus
        do_load(64'h7);
        do_step();
        check("t3_edge1", grid_out, 64'h202);
        do_step();
        check("t3_edge2", grid_out, 64'h0);
        check("t3_extinct", 64'(extinct), 64'd1);
        wrap_en = 1'b1;
        do_load(64'h7);
        do_step();
        check("t3_wrap", grid_out, (64'd1 << 57) | 64'h202);

        // block auto-halt; step ignored while halted
        wrap_en = 1'b0;
        do_load(64'h303);
        run = 1'b1;
        cyc();
        cyc();
        check("t2_stable", 64'(stable), 64'd1);
        check("t2_halt", 64'(running), 64'd0);
        check("t2_gen", 64'(gen_count), 64'd1);
        for (int i = 0; i < 10; i++) begin
            step = i[0];
            cyc();
        end
        step = 1'b0;
        check("t2_frozen", grid_out, 64'h303);
        run = 1'b0;
        cyc();

        // divider on u_div
        do_load(blk_h);
        run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("t4_gen_a", 64'(div_gen), (k >= 4) ? 64'd1 : 64'd0);
        end
        check("t4_grid", div_grid, blk_v);
        check("t4_div_stable", 64'(div_stable), 64'd0);
        check("t4_div_extinct", 64'(div_extinct), 64'd0);
        run = 1'b0;
        cyc();
        check("t4_hold", 64'(div_gen), 64'd1);
        check("t4_paused", 64'(div_running), 64'd0);
        run = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cyc();
            check("t4_gen_b", 64'(div_gen), (j >= 4) ? 64'd2 : 64'd1);
        end
        for (int j = 0; j < 40; j++) cyc();
        check("t4_saturate", 64'(div_gen), 64'd7);
        check("t4_div_run", 64'(div_running), 64'd1);

        // load + step in RUN: load wins; all-ones torus dies
        wrap_en = 1'b1;
        seed = '1;
        load = 1'b1;
        step = 1'b1;
        cyc();
        load = 1'b0;
        step = 1'b0;
        check("t5_ones", grid_out, '1);
        check("t5_gen0", 64'(gen_count), 64'd0);
        check("t5_idle", 64'(running), 64'd0);
        cyc();
        cyc();
        check("t5_dead", grid_out, 64'h0);
        check("t5_extinct", 64'(extinct), 64'd1);
        check("t5_halt", 64'(running), 64'd0);

        // async reset mid-run
        run = 1'b0;
        cyc();
        wrap_en = 1'b0;
        do_load(blk_h);
        run = 1'b1;
        cyc();
        cyc();
        cyc();
        #2 flopreset = 1'b1;
        model_reset();
        #1;
        check_all();
        check("t6_gen", 64'(gen_count), 64'd0);
        check("t6_running", 64'(running), 64'd0);
        check("t6_div_gen", 64'(div_gen), 64'd0);
        #1 flopreset = 1'b0;

        // random mix of load/run/step/wrap/show_seed
        for (int i = 0; i < 400; i++) begin
            seed = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) seed = seed & {$urandom, $urandom};
            load = ($urandom_range(0, 15) == 0);
            step = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) run = ~run;
            if ($urandom_range(0, 19) == 0) wrap_en = 1'($urandom);
            show_seed = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
